// File: rtl/arp_parser.sv
// ARP payload parser: checks the fixed ARP header, extracts opcode and sender/target addresses.
// Latency: arp_valid rises 1 cycle after the accepting tlast beat; arp_err pulses 1 cycle after the rejecting beat.
// Backpressure: s_axis_tready is low while a result is held (HOLD) and stays low until arp_ready accepts it.
// Ports:
//   s_axis_aclk/s_axis_areset   clock, async active-high reset
//   s_axis_t{data,valid,ready,user,last}  byte stream; tuser marks byte 0, tlast marks the final (padding) byte
//   local_ip                    own IP, compared on the tlast beat to form arp_hit
//   arp_{opcode,srcMac,srcIP,destMac,destIP,hit,valid}/arp_ready  result word and handshake
//   arp_err/arp_err_cnt         reject/abort pulse and its saturating count
module arp_parser (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  input  logic [31:0] local_ip,
  output logic [15:0] arp_opcode,
  output logic [47:0] arp_srcMac,
  output logic [31:0] arp_srcIP,
  output logic [47:0] arp_destMac,
  output logic [31:0] arp_destIP,
  output logic        arp_hit,
  output logic        arp_valid,
  input  logic        arp_ready,
  output logic        arp_err,
  output logic [7:0]  arp_err_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FIELDS = 2'd1, S_DRAIN = 2'd2, S_HOLD = 2'd3} state_t;

  localparam logic [4:0] LAST_IDX = 5'd27;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [4:0]  w_idx;
  logic [7:0]  r_b [0:27];
  logic        r_tready;
  logic        r_valid;
  logic        r_err;
  logic        r_hit;
  logic [7:0]  r_err_cnt;

  logic        w_beat;
  logic        w_store;
  logic        w_err;
  logic        w_eval;
  logic        w_pass;
  logic        w_at_end;
  logic        w_hit_now;
  logic [15:0] w_op;
  logic [31:0] w_dip_now;

  assign w_beat = s_axis_tvalid & r_tready;
  assign w_op   = {r_b[6], r_b[7]};

  // Header bytes 0..7 are always registered by the time a frame can complete.
  assign w_pass = ({r_b[0], r_b[1]} == 16'h0001) && ({r_b[2], r_b[3]} == 16'h0800) &&
                  (r_b[4] == 8'd6) && (r_b[5] == 8'd4) &&
                  ((w_op == 16'd1) || (w_op == 16'd2));

  // A tlast beat completes a frame only in DRAIN or when it carries byte 27.
  assign w_at_end = (r_state == S_DRAIN) || (r_cnt == LAST_IDX);

  // When tlast lands on byte 27 the last target-IP byte is still on the bus.
  assign w_dip_now = (r_state == S_FIELDS) ? {r_b[24], r_b[25], r_b[26], s_axis_tdata}
                                           : {r_b[24], r_b[25], r_b[26], r_b[27]};
  assign w_hit_now = (w_op == 16'd1) && (w_dip_now == local_ip);

  // State register
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_beat && s_axis_tuser && !s_axis_tlast) w_next = S_FIELDS;
      end
      S_FIELDS, S_DRAIN: begin
        if (w_beat) begin
          if (s_axis_tuser)                                   w_next = s_axis_tlast ? S_IDLE : S_FIELDS;
          else if (s_axis_tlast)                              w_next = (w_at_end && w_pass) ? S_HOLD : S_IDLE;
          else if (r_state == S_FIELDS && r_cnt == LAST_IDX)  w_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (r_valid && arp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state datapath controls
  always_comb begin
    w_store   = 1'b0;
    w_idx     = r_cnt;
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    w_eval    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_beat && s_axis_tuser) begin
          w_store   = 1'b1;
          w_idx     = 5'd0;
          w_cnt_nxt = 5'd1;
          w_err     = s_axis_tlast;
        end
      end
      S_FIELDS, S_DRAIN: begin
        if (w_beat) begin
          if (s_axis_tuser) begin
            // Restart: the byte in flight is byte 0 of a new frame.
            w_store   = 1'b1;
            w_idx     = 5'd0;
            w_cnt_nxt = 5'd1;
            w_err     = 1'b1;
          end else begin
            w_store   = (r_state == S_FIELDS);
            w_cnt_nxt = (r_state == S_FIELDS) ? r_cnt + 5'd1 : r_cnt;
            if (s_axis_tlast) begin
              w_cnt_nxt = 5'd0;
              if (w_at_end && w_pass) w_eval = 1'b1;
              else                    w_err  = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_cnt     <= 5'd0;
      r_tready  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_hit     <= 1'b0;
      r_err_cnt <= 8'd0;
      for (int i = 0; i < 28; i++) r_b[i] <= 8'd0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_tready <= (w_next != S_HOLD);
      r_valid  <= (w_next == S_HOLD);
      r_err    <= w_err;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_eval) r_hit <= w_hit_now;
      for (int i = 0; i < 28; i++) begin
        if (w_store && w_idx == 5'(i)) r_b[i] <= s_axis_tdata;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign arp_valid     = r_valid;
  assign arp_err       = r_err;
  assign arp_err_cnt   = r_err_cnt;
  assign arp_hit       = r_hit;
  assign arp_opcode    = w_op;
  assign arp_srcMac    = {r_b[8], r_b[9], r_b[10], r_b[11], r_b[12], r_b[13]};
  assign arp_srcIP     = {r_b[14], r_b[15], r_b[16], r_b[17]};
  assign arp_destMac   = {r_b[18], r_b[19], r_b[20], r_b[21], r_b[22], r_b[23]};
  assign arp_destIP    = {r_b[24], r_b[25], r_b[26], r_b[27]};

endmodule
